// File: rtl/writeback_ctrl_pkg.sv
// Shared phase encoding and default widths for the writeback controller.
package writeback_ctrl_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [2:0] {
        PH_WB       = 3'd1,
        PH_FETCH    = 3'd2,
        PH_DECODE   = 3'd3,
        PH_EXEC     = 3'd4,
        PH_WAIT_MEM = 3'd5
    } phase_t;

endpackage

// File: rtl/wb_mem_timer.sv
// Loadable down-counter bounding the wait for load data; expired when it reaches zero.
// Clear has priority over load, load over decrement; the count stops at zero.
module wb_mem_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/writeback_ctrl.sv
// Phase sequencer owning the register-file write port; ALU write 1 cycle after EXECUTE, loads 2 + memory latency.
// No backpressure: loads wait up to MEM_TIMEOUT cycles. Optional macro WB_R0_ZERO_EN hardwires register 0.
module writeback_ctrl
    import writeback_ctrl_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              ex_wen,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] ex_dest,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        fsm_state,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    output logic [15:0]       retire_cnt,
    output logic              mem_err
);

    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

    phase_t            r_state;
    phase_t            w_state_n;
    logic              r_pend;
    logic              w_pend_n;
    logic [ADDR_W-1:0] r_dest;
    logic [ADDR_W-1:0] w_dest_n;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_n;
    logic [ADDR_W-1:0] r_rf_addr;
    logic [DATA_W-1:0] r_rf_data;
    logic              r_mem_req;
    logic              w_req_n;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] w_addr_n;
    logic [15:0]       r_retire_cnt;
    logic              r_mem_err;
    logic              w_err_set;
    logic              w_tmr_clr;
    logic              w_tmr_load;
    logic              w_tmr_en;
    logic              w_tmr_expired;
    logic              w_exec_wen;
    logic              w_load_wen;
    logic              w_wb_entry;

`ifdef WB_R0_ZERO_EN
    assign w_exec_wen = ex_wen && (ex_dest != '0);
    assign w_load_wen = (r_dest != '0);
`else
    assign w_exec_wen = ex_wen;
    assign w_load_wen = 1'b1;
`endif

    wb_mem_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_tmr_clr),
        .i_load     (w_tmr_load),
        .i_load_val (TMR_W'(MEM_TIMEOUT - 1)),
        .i_en       (w_tmr_en),
        .o_expired  (w_tmr_expired)
    );

    always_comb begin
        w_state_n  = r_state;
        w_pend_n   = r_pend;
        w_dest_n   = r_dest;
        w_data_n   = r_data;
        w_req_n    = 1'b0;
        w_addr_n   = r_mem_addr;
        w_err_set  = 1'b0;
        w_tmr_clr  = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_en   = 1'b0;
        case (r_state)
            PH_FETCH: begin
                if (run) begin
                    w_state_n = PH_DECODE;
                end
            end
            PH_DECODE: w_state_n = PH_EXEC;
            PH_EXEC: begin
                w_dest_n = ex_dest;
                if (ex_is_load) begin
                    w_addr_n   = ex_data;
                    w_req_n    = 1'b1;
                    w_pend_n   = 1'b0;
                    w_tmr_load = 1'b1;
                    w_state_n  = PH_WAIT_MEM;
                end else begin
                    w_data_n  = ex_data;
                    w_pend_n  = w_exec_wen;
                    w_state_n = PH_WB;
                end
            end
            PH_WAIT_MEM: begin
                w_tmr_en = 1'b1;
                // Data arriving on the final allowed cycle still wins over the abort.
                if (mem_valid) begin
                    w_data_n  = mem_rdata;
                    w_pend_n  = w_load_wen;
                    w_tmr_clr = 1'b1;
                    w_state_n = PH_WB;
                end else if (w_tmr_expired) begin
                    w_pend_n  = 1'b0;
                    w_err_set = 1'b1;
                    w_tmr_clr = 1'b1;
                    w_state_n = PH_WB;
                end
            end
            PH_WB:   w_state_n = PH_FETCH;
            default: w_state_n = PH_FETCH;
        endcase
    end

    assign w_wb_entry = (w_state_n == PH_WB) && (r_state != PH_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= PH_FETCH;
            r_pend       <= 1'b0;
            r_dest       <= '0;
            r_data       <= '0;
            r_rf_addr    <= '0;
            r_rf_data    <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_retire_cnt <= '0;
            r_mem_err    <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_pend     <= w_pend_n;
            r_dest     <= w_dest_n;
            r_data     <= w_data_n;
            r_mem_req  <= w_req_n;
            r_mem_addr <= w_addr_n;
            // The visible write address/data only move for a real write.
            if (w_wb_entry && w_pend_n) begin
                r_rf_addr <= w_dest_n;
                r_rf_data <= w_data_n;
            end
            if (r_state == PH_WB) begin
                r_retire_cnt <= r_retire_cnt + 16'd1;
            end
            if (w_err_set) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    // Both terms are flops, so reset drops the strobe immediately.
    assign rf_we      = (r_state == PH_WB) && r_pend;
    assign fsm_state  = r_state;
    assign rf_addr    = r_rf_addr;
    assign rf_data    = r_rf_data;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign retire_cnt = r_retire_cnt;
    assign mem_err    = r_mem_err;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed bench for writeback_ctrl with a write-expectation scoreboard; outputs sampled on the falling edge.
module tb_writeback_ctrl;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        ex_wen;
    logic        ex_is_load;
    logic [3:0]  ex_dest;
    logic [15:0] ex_data;
    logic        mem_valid;
    logic [15:0] mem_rdata;
    logic [2:0]  fsm_state;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [15:0] rf_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] retire_cnt;
    logic        mem_err;

    writeback_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .ex_wen     (ex_wen),
        .ex_is_load (ex_is_load),
        .ex_dest    (ex_dest),
        .ex_data    (ex_data),
        .mem_valid  (mem_valid),
        .mem_rdata  (mem_rdata),
        .fsm_state  (fsm_state),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .retire_cnt (retire_cnt),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [3:0]  last_addr;
    logic [15:0] last_data;
    logic [15:0] exp_ret;
    logic        exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic eff_we(input logic wen, input logic [3:0] dest);
`ifdef WB_R0_ZERO_EN
        return wen && (dest != 4'd0);
`else
        return wen;
`endif
    endfunction

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (fsm_state !== s && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(fsm_state), 32'(s));
    endtask

    // Called at the falling edge inside WRITEBACK; returns at the falling edge in FETCH.
    task automatic check_wb(input string tag);
        exp_t e;
        chk({tag, "_wb_state"}, 32'(fsm_state), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.we) begin
                last_addr = e.addr;
                last_data = e.data;
            end
            chk({tag, "_rf_we"}, 32'(rf_we), 32'(e.we));
            chk({tag, "_rf_addr"}, 32'(rf_addr), 32'(last_addr));
            chk({tag, "_rf_data"}, 32'(rf_data), 32'(last_data));
        end
        @(negedge clk);
        exp_ret = exp_ret + 16'd1;
        chk({tag, "_fetch"}, 32'(fsm_state), 32'd2);
        chk({tag, "_rf_we_off"}, 32'(rf_we), 32'd0);
        chk({tag, "_retire"}, 32'(retire_cnt), 32'(exp_ret));
        chk({tag, "_mem_err"}, 32'(mem_err), 32'(exp_err));
    endtask

    task automatic alu(input logic wen, input logic [3:0] dest, input logic [15:0] data, input string tag);
        wait_state(3'd4, {tag, "_exec"});
        ex_is_load = 1'b0;
        ex_wen     = wen;
        ex_dest    = dest;
        ex_data    = data;
        sb.push_back('{we: eff_we(wen, dest), addr: dest, data: data});
        @(negedge clk);
        ex_wen  = 1'b1;
        ex_dest = 4'hF;
        ex_data = 16'hDEAD;
        check_wb(tag);
    endtask

    // d = WAIT_MEM cycle on which mem_valid is raised; d > TMO means never.
    task automatic load(input logic [3:0] dest, input logic [15:0] addr, input int d,
                        input logic [15:0] rdata, input string tag);
        wait_state(3'd4, {tag, "_exec"});
        ex_is_load = 1'b1;
        ex_wen     = 1'b0;
        ex_dest    = dest;
        ex_data    = addr;
        @(negedge clk);
        ex_is_load = 1'b0;
        ex_dest    = 4'hF;
        ex_data    = 16'hDEAD;
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(addr));
        for (int k = 1; k <= TMO; k++) begin
            chk({tag, "_wait_state"}, 32'(fsm_state), 32'd5);
            chk({tag, "_wait_rf_we"}, 32'(rf_we), 32'd0);
            if (k > 1) chk({tag, "_req_pulse"}, 32'(mem_req), 32'd0);
            if (k == d) begin
                mem_valid = 1'b1;
                mem_rdata = rdata;
                sb.push_back('{we: eff_we(1'b1, dest), addr: dest, data: rdata});
                @(negedge clk);
                mem_valid = 1'b0;
                break;
            end else if (k == TMO) begin
                sb.push_back('{we: 1'b0, addr: dest, data: 16'h0});
                exp_err = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        check_wb(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(fsm_state), 32'd2);
        chk({tag, "_rf_we"}, 32'(rf_we), 32'd0);
        chk({tag, "_rf_addr"}, 32'(rf_addr), 32'd0);
        chk({tag, "_rf_data"}, 32'(rf_data), 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_retire"}, 32'(retire_cnt), 32'd0);
        chk({tag, "_mem_err"}, 32'(mem_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        run        = 1'b0;
        ex_wen     = 1'b0;
        ex_is_load = 1'b0;
        ex_dest    = 4'd0;
        ex_data    = 16'd0;
        mem_valid  = 1'b0;
        mem_rdata  = 16'd0;
        exp_ret    = 16'd0;
        exp_err    = 1'b0;
        last_addr  = 4'd0;
        last_data  = 16'd0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        chk("park_no_run", 32'(fsm_state), 32'd2);

        run = 1'b1;
        alu(1'b1, 4'd5, 16'h1234, "alu1");
        alu(1'b1, 4'd9, 16'hA5A5, "alu2");
        alu(1'b0, 4'd7, 16'hFFFF, "alu_nowrite");
        load(4'd3, 16'h0040, 3, 16'hBEEF, "load3");
        load(4'd1, 16'h0080, 1, 16'h1357, "load1");
        load(4'd6, 16'h00C0, TMO, 16'h2468, "load_last");

        wait_state(3'd3, "halt_decode");
        run = 1'b0;
        alu(1'b1, 4'd6, 16'h6666, "halt");
        repeat (3) begin
            @(negedge clk);
            chk("halt_parked", 32'(fsm_state), 32'd2);
        end
        run = 1'b1;
        @(negedge clk);
        chk("resume_decode", 32'(fsm_state), 32'd3);

        load(4'd4, 16'h0100, TMO + 10, 16'h0000, "timeout");
        alu(1'b1, 4'd2, 16'h0F0F, "after_err");
        alu(1'b1, 4'd0, 16'h00AA, "r0");

        run = 1'b0;
        @(negedge clk);
        force dut.r_retire_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_retire_cnt;
        @(negedge clk);
        exp_ret = 16'hFFFF;
        chk("preload", 32'(retire_cnt), 32'(exp_ret));
        run = 1'b1;
        alu(1'b1, 4'd8, 16'h8888, "wrap");

        wait_state(3'd4, "rst_exec");
        ex_is_load = 1'b1;
        ex_dest    = 4'd2;
        ex_data    = 16'h0200;
        @(negedge clk);
        ex_is_load = 1'b0;
        chk("rst_wait", 32'(fsm_state), 32'd5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        exp_ret   = 16'd0;
        exp_err   = 1'b0;
        last_addr = 4'd0;
        last_data = 16'd0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_rf_we", 32'(rf_we), 32'd0);
        end
        rst_n = 1'b1;
        alu(1'b1, 4'd11, 16'hC0DE, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_ctrl.md
Name: writeback_ctrl

Overview:
- Sequences the processor's FETCH, DECODE, EXECUTE and WRITEBACK phases.
- Owns the producer side of the register-file write port: drives write enable, write address and write data.
- Takes ALU results, or load data after a memory handshake, from EXECUTE and commits them during WRITEBACK.
- Sits between the execute/memory path and the register file.

Parameters:
- DATA_W, 16, datapath and register width.
- ADDR_W, 4, register address width (16 registers).
- MEM_TIMEOUT, 15, maximum cycles spent in WAIT_MEM before abort; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  when low, the FSM parks in FETCH after finishing the current instruction.
- ex_wen  in  1  instruction in EXECUTE writes a register.
- ex_is_load  in  1  instruction in EXECUTE is a load; ex_data is the address.
- ex_dest  in  ADDR_W  destination register.
- ex_data  in  DATA_W  ALU result, or load address.
- mem_valid  in  1  load data valid.
- mem_rdata  in  DATA_W  load data.
- fsm_state  out  3  phase code: 1=WRITEBACK, 2=FETCH, 3=DECODE, 4=EXECUTE, 5=WAIT_MEM.
- rf_we  out  1  register-file write strobe.
- rf_addr  out  ADDR_W  write address.
- rf_data  out  DATA_W  write data.
- mem_req  out  1  one-cycle load request pulse.
- mem_addr  out  DATA_W  load address, held until mem_valid.
- retire_cnt  out  16  retired-instruction counter.
- mem_err  out  1  sticky load-timeout flag.

Behaviour:
- Reset (async assert, sync release):
  - fsm_state=2 (FETCH).
  - rf_we=0, rf_addr=0, rf_data=0.
  - mem_req=0, mem_addr=0.
  - retire_cnt=0, mem_err=0.
  - Pending-write flag cleared, timeout counter cleared.
- Transitions, one per clock:
  - FETCH->DECODE when run=1; otherwise stay in FETCH.
  - DECODE->EXECUTE unconditionally.
  - EXECUTE:
    - If ex_is_load: latch ex_dest, set mem_addr=ex_data, pulse mem_req for exactly one cycle, go to WAIT_MEM.
    - Else: latch ex_dest, ex_data and ex_wen into the pending buffer, go to WRITEBACK.
  - WAIT_MEM:
    - Timeout counter increments each cycle.
    - mem_valid=1: capture mem_rdata, set pending, go to WRITEBACK.
    - Counter reaches MEM_TIMEOUT without mem_valid: clear pending, set mem_err=1, go to WRITEBACK.
    - mem_valid takes priority over timeout in the same cycle.
    - mem_valid outside WAIT_MEM is ignored.
  - WRITEBACK:
    - rf_we=pending for exactly this one cycle; rf_addr and rf_data come from the buffer.
    - retire_cnt increments, wrapping 0xFFFF->0x0000; it increments even on an aborted load.
    - Go to FETCH.
- rf_we is 0 in every state other than WRITEBACK. rf_addr and rf_data hold their last values outside WRITEBACK.
- The register file samples on the same clk edge. Write latency from EXECUTE:
  - ALU instruction: 1 cycle.
  - Load: 2 cycles plus memory latency.
- Full ALU instruction: 4 cycles. Load with mem_valid on the first WAIT_MEM cycle: 5 cycles.
- run deasserted mid-instruction: the instruction completes; only the FETCH->DECODE transition is gated.
- mem_err clears only on reset.
- Async reset during WAIT_MEM or WRITEBACK aborts with no write; no partial rf_we pulse is allowed.
- ex_* inputs are sampled only in EXECUTE.

Optional Feature:
- Macro: WB_R0_ZERO_EN.
- When defined: register 0 is hardwired.
  - Any write with destination 0 drives rf_we=0 in WRITEBACK.
  - The instruction still retires, and retire_cnt still increments.
- When undefined: register 0 is an ordinary writable register.

Decomposition:
- Shared package holds:
  - Phase encoding constants: PH_WB=1, PH_FETCH=2, PH_DECODE=3, PH_EXEC=4, PH_WAIT_MEM=5.
  - DATA_W and ADDR_W defaults.
  - A phase typedef (3 bits).
- Sub-module wb_mem_timer: a loadable down-counter with a clear and an expired flag, used for the WAIT_MEM timeout.
- Everything else stays in a single module.

Test Plan:
- ALU write: reset, run=1; in EXECUTE ex_wen=1, ex_dest=5, ex_data=0x1234 -> next cycle fsm_state=1, rf_we=1, rf_addr=5, rf_data=0x1234; retire_cnt=1.
- Load: ex_is_load=1, ex_dest=3, ex_data=0x0040 -> mem_req pulses 1 cycle with mem_addr=0x0040; mem_valid=1, mem_rdata=0xBEEF after 3 cycles -> WRITEBACK with rf_addr=3, rf_data=0xBEEF.
- Timeout: load with mem_valid never asserted -> WRITEBACK after 15 WAIT_MEM cycles with rf_we=0; mem_err=1 and stays 1.
- Halt: run=0 during DECODE -> instruction completes through WRITEBACK, then fsm_state stays 2; run=1 -> DECODE on the next cycle.
- Wrap and reset: preload retire_cnt to 0xFFFF via 65535 instructions (or force) -> next retire gives 0x0000; rst_n=0 asynchronously in WAIT_MEM -> all outputs at reset values immediately, and no rf_we.
- WB_R0_ZERO_EN defined: ex_dest=0, ex_wen=1 -> rf_we=0 in WRITEBACK and retire_cnt increments. Undefined: rf_we=1.
